// File: rtl/piano_key_debouncer_if.sv
// Key-conditioning bus: raw active-low key contacts in, encoded debounced key state out.
// The master drives the raw contacts; the slave (the debouncer) drives the results.
interface piano_key_debouncer_if #(
    parameter int NUM_KEYS = 7
);
    logic [NUM_KEYS-1:0] keys_n;
    logic [3:0]          key_id;
    logic                key_pressed;
    logic                key_change_pulse;
    logic                multi_key;
    logic [NUM_KEYS-1:0] debounced_keys;

    modport master (
        output keys_n,
        input  key_id,
        input  key_pressed,
        input  key_change_pulse,
        input  multi_key,
        input  debounced_keys
    );

    modport slave (
        input  keys_n,
        output key_id,
        output key_pressed,
        output key_change_pulse,
        output multi_key,
        output debounced_keys
    );
endinterface

// File: rtl/piano_key_debouncer.sv
// Per-key two-flop synchroniser and symmetric debounce counter.
// A registered lowest-index priority encoder sits behind them and raises a pulse on each new nonzero key_id.
module piano_key_debouncer #(
    parameter int NUM_KEYS        = 7,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    piano_key_debouncer_if.slave    bus
);
    localparam int                  CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1'b1);

    logic [NUM_KEYS-1:0] meta_q;
    logic [NUM_KEYS-1:0] sync2_q;
    logic [NUM_KEYS-1:0] sync_s;
    logic [NUM_KEYS-1:0] deb_q;
    logic [NUM_KEYS-1:0] deb_d;
    logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_d [NUM_KEYS];

    logic [3:0]          key_id_d;
    logic [3:0]          pop_s;
    logic                multi_d;
    logic                pulse_d;

    logic [3:0]          key_id_q;
    logic                key_pressed_q;
    logic                pulse_q;
    logic                multi_q;
    logic [NUM_KEYS-1:0] deb_out_q;

    // Contacts are active-low; the second stage inverts to active-high "pressed".
    assign sync_s = ~sync2_q;

    // Debounce next state: any matching sample restarts the interval, reaching the end flips the key.
    always_comb begin
        deb_d = deb_q;
        for (int k = 0; k < NUM_KEYS; k++) begin
            cnt_d[k] = {CNT_W{1'b0}};
            if (sync_s[k] == deb_q[k]) begin
                cnt_d[k] = {CNT_W{1'b0}};
            end else if (cnt_q[k] == CNT_MAX) begin
                deb_d[k] = ~deb_q[k];
                cnt_d[k] = {CNT_W{1'b0}};
            end else begin
                cnt_d[k] = cnt_q[k] + CNT_ONE;
            end
        end
    end

    // Synchroniser chain, debounce counters and debounced state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= {NUM_KEYS{1'b1}};
            sync2_q <= {NUM_KEYS{1'b1}};
            deb_q   <= {NUM_KEYS{1'b0}};
            for (int k = 0; k < NUM_KEYS; k++) begin
                cnt_q[k] <= {CNT_W{1'b0}};
            end
        end else begin
            meta_q  <= bus.keys_n;
            sync2_q <= meta_q;
            deb_q   <= deb_d;
            for (int k = 0; k < NUM_KEYS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    // Encoder: scan from the top down so the lowest pressed index wins; popcount for multi_key.
    always_comb begin
        key_id_d = 4'd0;
        pop_s    = 4'd0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            key_id_d = deb_q[k] ? 4'(k + 1) : key_id_d;
            pop_s    = pop_s + {3'b000, deb_q[k]};
        end
        multi_d = (pop_s >= 4'd2);
        pulse_d = (key_id_d != 4'd0) && (key_id_d != key_id_q);
    end

    // Registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_id_q      <= 4'd0;
            key_pressed_q <= 1'b0;
            pulse_q       <= 1'b0;
            multi_q       <= 1'b0;
            deb_out_q     <= {NUM_KEYS{1'b0}};
        end else begin
            key_id_q      <= key_id_d;
            key_pressed_q <= |deb_q;
            pulse_q       <= pulse_d;
            multi_q       <= multi_d;
            deb_out_q     <= deb_q;
        end
    end

    assign bus.key_id           = key_id_q;
    assign bus.key_pressed      = key_pressed_q;
    assign bus.key_change_pulse = pulse_q;
    assign bus.multi_key        = multi_q;
    assign bus.debounced_keys   = deb_out_q;
endmodule

// File: tb/tb_piano_key_debouncer.sv
// Directed bench for piano_key_debouncer with DEBOUNCE_CYCLES = 4 (clean transitions appear at edge 7).
module tb_piano_key_debouncer;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mis;
    int   pulses;

    piano_key_debouncer_if #(.NUM_KEYS(7)) bus ();

    piano_key_debouncer #(
        .NUM_KEYS        (7),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance past one rising edge and settle at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Advance n edges, accumulating key_change_pulse into pulses.
    task automatic run_edges(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            pulses += int'(bus.key_change_pulse);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_cmp       = 0;
        n_mis       = 0;
        pulses      = 0;
        rst_n       = 1'b0;
        bus.keys_n  = 7'h7F;
        #12;
        check_val("rst_key_id", 32'(bus.key_id), 32'd0);
        check_val("rst_pressed", 32'(bus.key_pressed), 32'd0);
        check_val("rst_pulse", 32'(bus.key_change_pulse), 32'd0);
        check_val("rst_multi", 32'(bus.multi_key), 32'd0);
        check_val("rst_deb", 32'(bus.debounced_keys), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();

        // Clean press of bit 0.
        bus.keys_n[0] = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_val("t1_quiet", {25'd0, bus.key_id, bus.key_pressed, bus.key_change_pulse, bus.multi_key}, 32'd0);
        end
        tick();
        check_val("t1_key_id", 32'(bus.key_id), 32'd1);
        check_val("t1_pressed", 32'(bus.key_pressed), 32'd1);
        check_val("t1_pulse", 32'(bus.key_change_pulse), 32'd1);
        tick();
        check_val("t1_pulse_end", 32'(bus.key_change_pulse), 32'd0);
        check_val("t1_hold", 32'(bus.key_id), 32'd1);

        // Release bit 0.
        bus.keys_n[0] = 1'b1;
        pulses = 0;
        run_edges(6);
        check_val("t1r_early", 32'(bus.key_id), 32'd1);
        run_edges(1);
        check_val("t1r_key_id", 32'(bus.key_id), 32'd0);
        check_val("t1r_pulses", 32'(pulses), 32'd0);

        // Bounce on bit 4: 3 cycles pressed, 1 released, then held.
        pulses = 0;
        bus.keys_n[4] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_edges(1);
            check_val("t2_glitch", 32'(bus.key_id), 32'd0);
        end
        bus.keys_n[4] = 1'b1;
        run_edges(1);
        check_val("t2_gap", 32'(bus.key_id), 32'd0);
        bus.keys_n[4] = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            run_edges(1);
            check_val("t2_wait", 32'(bus.key_id), 32'd0);
        end
        run_edges(1);
        check_val("t2_key_id", 32'(bus.key_id), 32'd5);
        check_val("t2_pulse", 32'(bus.key_change_pulse), 32'd1);
        run_edges(1);
        check_val("t2_pulses", 32'(pulses), 32'd1);

        // Priority: bit 1 joins bit 4.
        pulses = 0;
        bus.keys_n[1] = 1'b0;
        run_edges(6);
        check_val("t3_early", 32'(bus.key_id), 32'd5);
        run_edges(1);
        check_val("t3_key_id", 32'(bus.key_id), 32'd2);
        check_val("t3_multi", 32'(bus.multi_key), 32'd1);
        run_edges(1);
        check_val("t3_pulses", 32'(pulses), 32'd1);

        // Release bit 1: bit 4 takes over again.
        pulses = 0;
        bus.keys_n[1] = 1'b1;
        run_edges(7);
        check_val("t3r_key_id", 32'(bus.key_id), 32'd5);
        check_val("t3r_multi", 32'(bus.multi_key), 32'd0);
        run_edges(1);
        check_val("t3r_pulses", 32'(pulses), 32'd1);

        // Release bit 4.
        pulses = 0;
        bus.keys_n[4] = 1'b1;
        run_edges(7);
        check_val("t3z_key_id", 32'(bus.key_id), 32'd0);
        check_val("t3z_pulses", 32'(pulses), 32'd0);

        // Release from key_id 3.
        pulses = 0;
        bus.keys_n[2] = 1'b0;
        run_edges(7);
        check_val("t4_key_id", 32'(bus.key_id), 32'd3);
        check_val("t4_pulses", 32'(pulses), 32'd1);
        pulses = 0;
        bus.keys_n[2] = 1'b1;
        run_edges(6);
        check_val("t4_early", 32'(bus.key_id), 32'd3);
        run_edges(1);
        check_val("t4_released", 32'(bus.key_id), 32'd0);
        check_val("t4_pressed", 32'(bus.key_pressed), 32'd0);
        check_val("t4_pulses", 32'(pulses), 32'd0);

        // Async reset while bit 2 is held and bit 0 is mid-count.
        bus.keys_n[2] = 1'b0;
        run_edges(7);
        check_val("t5_pre", 32'(bus.key_id), 32'd3);
        bus.keys_n[0] = 1'b0;
        run_edges(3);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t5_rst_key_id", 32'(bus.key_id), 32'd0);
        check_val("t5_rst_pressed", 32'(bus.key_pressed), 32'd0);
        check_val("t5_rst_deb", 32'(bus.debounced_keys), 32'd0);
        bus.keys_n[0] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 6; i++) begin
            run_edges(1);
            check_val("t5_wait", 32'(bus.key_id), 32'd0);
        end
        run_edges(1);
        check_val("t5_key_id", 32'(bus.key_id), 32'd3);
        check_val("t5_pulse", 32'(bus.key_change_pulse), 32'd1);

        // Two keys (bits 0 and 6) on the same edge.
        bus.keys_n[2] = 1'b1;
        run_edges(7);
        check_val("t6_clear", 32'(bus.key_id), 32'd0);
        pulses = 0;
        bus.keys_n = 7'b0111110;
        run_edges(6);
        check_val("t6_early", 32'(bus.debounced_keys), 32'd0);
        run_edges(1);
        check_val("t6_deb", 32'(bus.debounced_keys), 32'h41);
        check_val("t6_key_id", 32'(bus.key_id), 32'd1);
        check_val("t6_multi", 32'(bus.multi_key), 32'd1);
        check_val("t6_pulse", 32'(bus.key_change_pulse), 32'd1);
        run_edges(1);
        check_val("t6_pulses", 32'(pulses), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
